// File: rtl/segasys1_pkg.sv
// Shared types and constants for the Sega System 1 sound-command path.
package segasys1_pkg;

  localparam int SNDCMD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } nmi_state_e;

endpackage

// File: rtl/segasys1_sync_fifo.sv
// Single-clock FIFO with occupancy count and show-ahead head output.
// A pop on a full FIFO frees the slot that a simultaneous push then fills.
module segasys1_sync_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic [WIDTH-1:0]      head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers gate
  // every read, so stale contents are never observed and the array can map
  // onto plain RAM without a reset port.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/segasys1_sndcmd_queue.sv
// Sound-command mailbox: queues main-CPU sound writes and paces one NMI per
// queued command to the sound CPU, with a guaranteed low gap between NMIs.
module segasys1_sndcmd_queue
  import segasys1_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int NMI_GAP    = 16,
  parameter int NMI_TMO    = 0
) (
  input  logic                 CLK48M,
  input  logic                 RESET_N,
  input  logic                 SNDRQ,
  input  logic [SNDCMD_W-1:0]  SNDNO,
  input  logic                 SND_RD,
  output logic [SNDCMD_W-1:0]  SND_DO,
  output logic                 SND_NMI,
  output logic [DEPTH_LOG2:0]  CNT,
  output logic                 OVF,
  input  logic                 OVF_CLR
);

  localparam int GAP_W = $clog2(NMI_GAP);
  localparam int TMO_W = (NMI_TMO > 1) ? $clog2(NMI_TMO) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(NMI_GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((NMI_TMO > 0) ? NMI_TMO - 1 : 0);
  localparam bit               TMO_EN   = (NMI_TMO != 0);

  logic                fifo_full;
  logic                fifo_empty;
  logic [SNDCMD_W-1:0] fifo_head;
  logic                pop_ev;
  logic                drop;

  logic                snd_rd_d_q;
  logic [SNDCMD_W-1:0] snd_do_q, snd_do_d;
  logic                ovf_q, ovf_d;
  nmi_state_e          state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  // Pop on the trailing edge of a read so the byte stays stable throughout it.
  assign pop_ev = snd_rd_d_q & ~SND_RD;
  assign drop   = SNDRQ & fifo_full & ~pop_ev;

  segasys1_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (SNDCMD_W)
  ) u_fifo (
    .clk     (CLK48M),
    .rst_n   (RESET_N),
    .push_i  (SNDRQ),
    .pop_i   (pop_ev),
    .data_i  (SNDNO),
    .head_o  (fifo_head),
    .count_o (CNT),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    snd_do_d = fifo_empty ? snd_do_q : fifo_head;
    ovf_d    = drop ? 1'b1 : (OVF_CLR ? 1'b0 : ovf_q);

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ASSERT;
          tmo_d   = '0;
        end
      end
      ST_ASSERT: begin
        if (pop_ev) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          // Unacknowledged NMI: drop it and raise a fresh edge after the gap.
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK48M or negedge RESET_N) begin
    if (!RESET_N) begin
      snd_rd_d_q <= 1'b0;
      snd_do_q   <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      tmo_q      <= '0;
    end else begin
      snd_rd_d_q <= SND_RD;
      snd_do_q   <= snd_do_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
    end
  end

  assign SND_DO  = snd_do_q;
  assign SND_NMI = (state_q == ST_ASSERT);
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_segasys1_sndcmd_queue.sv
// Directed bench for segasys1_sndcmd_queue: a queue-level behavioural model
// is compared against the DUT every cycle, plus hand-computed scenario checks.
module tb_segasys1_sndcmd_queue;

  localparam int DEPTH_LOG2 = 2;
  localparam int NMI_GAP    = 16;
  localparam int NMI_TMO    = 100;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic                sndrq   = 1'b0;
  logic [7:0]          sndno   = 8'h00;
  logic                snd_rd  = 1'b0;
  logic                ovf_clr = 1'b0;
  logic [7:0]          snd_do;
  logic                snd_nmi;
  logic [DEPTH_LOG2:0] cnt;
  logic                ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  segasys1_sndcmd_queue #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .NMI_GAP    (NMI_GAP),
    .NMI_TMO    (NMI_TMO)
  ) dut (
    .CLK48M  (clk),
    .RESET_N (rst_n),
    .SNDRQ   (sndrq),
    .SNDNO   (sndno),
    .SND_RD  (snd_rd),
    .SND_DO  (snd_do),
    .SND_NMI (snd_nmi),
    .CNT     (cnt),
    .OVF     (ovf),
    .OVF_CLR (ovf_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a byte queue plus "how long has NMI been high" and
  // "how many more edges must NMI stay low" counters.
  logic [7:0] m_q[$];
  logic [7:0] m_do;
  bit         m_ovf, m_rd_prev, m_nmi;
  int         m_hi, m_wait;

  task automatic model_reset();
    m_q.delete();
    m_do = 8'h00; m_ovf = 1'b0; m_rd_prev = 1'b0; m_nmi = 1'b0;
    m_hi = 0; m_wait = 0;
  endtask

  task automatic model_step();
    bit pop_ev;
    int n;
    pop_ev = m_rd_prev && !snd_rd;
    n      = m_q.size();
    if (m_nmi) begin
      if (pop_ev || (NMI_TMO != 0 && m_hi == NMI_TMO)) begin
        m_nmi = 1'b0; m_wait = NMI_GAP;
      end else m_hi++;
    end else if (m_wait > 0) m_wait--;
    else if (n != 0) begin
      m_nmi = 1'b1; m_hi = 1;
    end
    if (n != 0) m_do = m_q[0];
    if (pop_ev && n != 0) void'(m_q.pop_front());
    if (sndrq && m_q.size() < DEPTH) m_q.push_back(sndno);
    if (sndrq && m_q.size() >= DEPTH && !(pop_ev && n != 0) && n == DEPTH) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_rd_prev = snd_rd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle compare plus NMI edge / low-run bookkeeping.
  int   rises = 0;
  int   low_run = 0;
  logic nmi_prev = 1'b0;
  int   gaps[$];

  initial forever begin
    @(negedge clk);
    check("model_cnt", cnt, m_q.size());
    check("model_do",  snd_do, m_do);
    check("model_nmi", snd_nmi, m_nmi);
    check("model_ovf", ovf, m_ovf);
    if (!rst_n) begin
      nmi_prev = 1'b0; low_run = 0;
    end else begin
      if (snd_nmi && !nmi_prev) begin
        rises++; gaps.push_back(low_run); low_run = 0;
      end
      if (!snd_nmi) low_run++;
      nmi_prev = snd_nmi;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    sndrq = 1'b1; sndno = b;
    tick();
    sndrq = 1'b0;
  endtask

  task automatic read_pulse(input int len, output logic [7:0] got);
    snd_rd = 1'b1;
    tick();
    got = snd_do;
    repeat (len - 1) tick();
    snd_rd = 1'b0;
    tick();
  endtask

  task automatic wait_nmi(input logic level, input int budget, input string name);
    int n = 0;
    while (snd_nmi !== level && n < budget) begin
      tick(); n++;
    end
    check(name, snd_nmi, level);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  logic [7:0] got;
  logic [7:0] exp4 [4];
  int r0, hi, lo;

  initial begin
    exp4[0] = 8'h11; exp4[1] = 8'h12; exp4[2] = 8'h13; exp4[3] = 8'h77;
    repeat (3) tick();
    rst_n = 1'b1;

    // 1: single command, NMI, read, pop after the read ends
    check("t1_rst_cnt", cnt, 0);
    check("t1_rst_do", snd_do, 8'h00);
    check("t1_rst_nmi", snd_nmi, 0);
    check("t1_rst_ovf", ovf, 0);
    push(8'h5A);
    check("t1_cnt1", cnt, 1);
    wait_nmi(1'b1, 2, "t1_nmi_rise");
    check("t1_do", snd_do, 8'h5A);
    read_pulse(4, got);
    check("t1_read", got, 8'h5A);
    check("t1_cnt0", cnt, 0);
    check("t1_nmi_low", snd_nmi, 0);
    check("t1_do_hold", snd_do, 8'h5A);
    repeat (25) tick();

    // 2: three back-to-back commands, each acked 10 cycles after its NMI
    gaps.delete();
    r0 = rises;
    push(8'h01); push(8'h02); push(8'h03);
    for (int i = 0; i < 3; i++) begin
      wait_nmi(1'b1, 60, "t2_nmi_rise");
      repeat (10) tick();
      read_pulse(2, got);
      check("t2_read", got, i + 1);
    end
    repeat (30) tick();
    check("t2_rises", rises - r0, 3);
    check("t2_ngaps", gaps.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < gaps.size()) check("t2_gap_ge16", gaps[i] >= NMI_GAP, 1);

    // 3: overflow with no reads, then clear
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("t3_cnt_full", cnt, 4);
    check("t3_ovf_set", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t3_ovf_clr", ovf, 0);

    // 4: push coinciding with the pop edge while full
    snd_rd = 1'b1; tick();
    check("t4_head", snd_do, 8'h10);
    snd_rd = 1'b0; sndrq = 1'b1; sndno = 8'h77;
    tick();
    sndrq = 1'b0;
    check("t4_cnt_full", cnt, 4);
    check("t4_ovf_zero", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      read_pulse(1, got);
      check("t4_read", got, exp4[i]);
    end
    check("t4_cnt0", cnt, 0);

    // 5: unread NMI times out and retriggers
    repeat (40) tick();
    push(8'hAB);
    wait_nmi(1'b1, 4, "t5_nmi_rise");
    hi = 0;
    while (snd_nmi && hi < 300) begin tick(); hi++; end
    check("t5_high_len", hi, 100);
    lo = 0;
    while (!snd_nmi && lo < 300) begin tick(); lo++; end
    check("t5_low_ge_gap", lo >= NMI_GAP, 1);
    check("t5_low_len", lo, 17);  // 16 gap cycles plus one idle cycle
    check("t5_cnt1", cnt, 1);

    // 6: async reset in the middle of an NMI
    read_pulse(1, got);
    check("t6_read_ab", got, 8'hAB);
    repeat (30) tick();
    push(8'hC1); push(8'hC2);
    wait_nmi(1'b1, 4, "t6_nmi_rise");
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_nmi", snd_nmi, 0);
    check("t6_rst_cnt", cnt, 0);
    check("t6_rst_do", snd_do, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    r0 = rises;
    repeat (30) tick();
    check("t6_no_nmi", rises - r0, 0);
    push(8'h3C);
    wait_nmi(1'b1, 4, "t6_nmi_after");
    check("t6_do", snd_do, 8'h3C);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
